// File: rtl/gate_test_sequencer_pkg.sv
// gate_test_sequencer_pkg: shared state encodings and gate truth tables
package gate_test_sequencer_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;
endpackage

// File: rtl/gate_test_sequencer_hold_timer.sv
// hold_timer: free-running 0..HOLD_CYCLES-1 counter with clear, enable and terminal-count flag
module hold_timer #(
   parameter int HOLD_CYCLES = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int W = $clog2(HOLD_CYCLES);
   logic [W-1:0] cnt;
   assign tc = cnt == W'(HOLD_CYCLES - 1);
   // count while enabled, wrapping to 0 after the terminal count
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= tc ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: walks a 2-input gate through all four vectors and checks y against a truth table
module gate_test_sequencer
   import gate_test_sequencer_pkg::*;
#(
   parameter int         HOLD_CYCLES = 10,
   parameter logic [3:0] EXP_TT      = 4'b1000,
   parameter int         CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   output logic             gate_a,
   output logic             gate_b,
   input  logic             gate_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       fail_mask,
   output logic [CNT_W-1:0] run_count
);
   logic [1:0] state;
   logic [1:0] idx;
   logic       tc;
   logic       go;
   logic [3:0] hit;
   assign go   = (state == ST_IDLE && start) || (state == ST_DONE && (start || continuous));
   assign hit  = (gate_y != EXP_TT[idx]) ? 4'b0001 << idx : 4'b0000;
   assign busy = state == ST_APPLY;
   assign done = state == ST_DONE;
   hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
      .clk(clk),
      .rst(rst),
      .clr(go),
      .en (busy),
      .tc (tc)
   );
   // sequencing FSM: launch, step vectors on each terminal count, and publish results on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         idx              <= 2'd0;
         {gate_a, gate_b} <= 2'b00;
         pass             <= 1'b0;
         fail_mask        <= 4'b0000;
         run_count        <= '0;
      end else if (go) begin
         state            <= ST_APPLY;
         idx              <= 2'd0;
         {gate_a, gate_b} <= 2'b00;
         fail_mask        <= 4'b0000;
      end else if (state == ST_DONE) begin
         state <= ST_IDLE;
      end else if (busy && tc) begin
         fail_mask <= fail_mask | hit;
         if (idx == 2'd3) begin
            state            <= ST_DONE;
            pass             <= ~|(fail_mask | hit);
            run_count        <= run_count + 1'b1;
            {gate_a, gate_b} <= 2'b00;
         end else begin
            idx              <= idx + 2'd1;
            {gate_a, gate_b} <= idx + 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: directed checks of the gate self-test sequencer against AND-gate models
module tb_gate_test_sequencer;
   import gate_test_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic start_and = 0, cont_and = 0, and_a, and_b, and_busy, and_done, and_pass;
   logic [3:0] and_mask;
   logic [7:0] and_rc;
   logic start_or = 0, or_a, or_b, or_busy, or_done, or_pass;
   logic [3:0] or_mask;
   logic [7:0] or_rc;
   logic start_c2 = 0, cont_c2 = 0, c2_a, c2_b, c2_busy, c2_done, c2_pass;
   logic [3:0] c2_mask;
   logic [1:0] c2_rc;

   gate_test_sequencer #(.HOLD_CYCLES(10), .EXP_TT(TT_AND), .CNT_W(8)) u_and (
      .clk(clk), .rst(rst), .start(start_and), .continuous(cont_and),
      .gate_a(and_a), .gate_b(and_b), .gate_y(and_a & and_b),
      .busy(and_busy), .done(and_done), .pass(and_pass),
      .fail_mask(and_mask), .run_count(and_rc));

   gate_test_sequencer #(.HOLD_CYCLES(10), .EXP_TT(TT_OR), .CNT_W(8)) u_or (
      .clk(clk), .rst(rst), .start(start_or), .continuous(1'b0),
      .gate_a(or_a), .gate_b(or_b), .gate_y(or_a & or_b),
      .busy(or_busy), .done(or_done), .pass(or_pass),
      .fail_mask(or_mask), .run_count(or_rc));

   gate_test_sequencer #(.HOLD_CYCLES(2), .EXP_TT(TT_AND), .CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .start(start_c2), .continuous(cont_c2),
      .gate_a(c2_a), .gate_b(c2_b), .gate_y(c2_a & c2_b),
      .busy(c2_busy), .done(c2_done), .pass(c2_pass),
      .fail_mask(c2_mask), .run_count(c2_rc));

   typedef struct {
      int   cyc;
      logic a, b, busy, done;
   } vec_t;
   vec_t tbl[10];

   int checks = 0;
   int errors = 0;
   int n_done;
   int done_cyc[8];
   logic [7:0] done_cnt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // cycle 0 is the current cycle (start already driven); records done pulses of DUT sel
   task automatic track(input int sel, input int limit, input int drop_after, input bit keep_start);
      n_done = 0;
      for (int c = 1; c <= limit; c++) begin
         step();
         if (c == 1 && !keep_start) begin
            start_and = 0;
            start_c2  = 0;
         end
         if ((sel == 0 ? and_done : c2_done) && n_done < 8) begin
            done_cyc[n_done] = c;
            done_cnt[n_done] = (sel == 0) ? and_rc : {6'b0, c2_rc};
            n_done++;
         end
         if (n_done == drop_after && n_done > 0 && c == done_cyc[n_done-1] + 5) begin
            start_and = 0;
            cont_and  = 0;
            cont_c2   = 0;
         end
      end
   endtask

   initial begin
      tbl[0] = '{1,  0, 0, 1, 0};
      tbl[1] = '{10, 0, 0, 1, 0};
      tbl[2] = '{11, 0, 1, 1, 0};
      tbl[3] = '{20, 0, 1, 1, 0};
      tbl[4] = '{21, 1, 0, 1, 0};
      tbl[5] = '{30, 1, 0, 1, 0};
      tbl[6] = '{31, 1, 1, 1, 0};
      tbl[7] = '{40, 1, 1, 1, 0};
      tbl[8] = '{41, 0, 0, 0, 1};
      tbl[9] = '{42, 0, 0, 0, 0};

      repeat (2) step();
      chk("reset_outputs", {and_a, and_b, and_busy, and_done, and_pass, and_mask, and_rc}, 0);
      rst = 0;
      step();

      // single AND run, table-driven waveform
      start_and = 1;
      for (int c = 1; c <= 45; c++) begin
         step();
         if (c == 1) start_and = 0;
         foreach (tbl[i])
            if (tbl[i].cyc == c) begin
               chk($sformatf("and_c%0d_ab", c), {and_a, and_b}, {tbl[i].a, tbl[i].b});
               chk($sformatf("and_c%0d_busy_done", c), {and_busy, and_done}, {tbl[i].busy, tbl[i].done});
            end
         if (c == 41) begin
            chk("and_pass", and_pass, 1);
            chk("and_mask", and_mask, 0);
            chk("and_run_count", and_rc, 1);
         end
      end

      // OR expectation against an AND gate
      start_or = 1;
      n_done = 0;
      for (int c = 1; c <= 60; c++) begin
         step();
         if (c == 1) start_or = 0;
         if (c == 15) chk("or_mask_live_v0", or_mask, 4'b0000);
         if (c == 25) chk("or_mask_live_v1", or_mask, 4'b0010);
         if (or_done) begin
            n_done++;
            chk("or_done_cycle", c, 41);
            chk("or_pass", or_pass, 0);
            chk("or_mask", or_mask, 4'b0110);
         end
      end
      chk("or_done_count", n_done, 1);
      chk("or_idle_keeps_mask", {or_busy, or_mask, or_pass}, {1'b0, 4'b0110, 1'b0});

      // start held through runs: one restart per DONE, no restart while busy
      start_and = 1;
      track(0, 200, 2, 1);
      chk("hold_done_count", n_done, 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("hold_done%0d_cyc", i), done_cyc[i], 41 * (i + 1));
         chk($sformatf("hold_done%0d_cnt", i), done_cnt[i], i + 2);
      end
      chk("hold_idle", {and_busy, and_rc}, {1'b0, 8'd4});

      // continuous for three runs from a fresh reset
      rst = 1;
      step();
      rst = 0;
      chk("reset2_run_count", and_rc, 0);
      start_and = 1;
      cont_and  = 1;
      track(0, 200, 2, 0);
      chk("cont_done_count", n_done, 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("cont_done%0d_cyc", i), done_cyc[i], 41 * (i + 1));
         chk($sformatf("cont_done%0d_cnt", i), done_cnt[i], i + 1);
      end
      chk("cont_idle", {and_busy, and_done, and_a, and_b, and_pass}, 5'b00001);

      // reset during a run
      start_and = 1;
      for (int c = 1; c <= 25; c++) begin
         step();
         if (c == 1) start_and = 0;
      end
      rst = 1;
      step();
      rst = 0;
      chk("midrun_reset_outputs", {and_a, and_b, and_busy, and_done, and_pass, and_mask, and_rc}, 0);
      n_done = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (and_done || and_busy) n_done++;
      end
      chk("midrun_reset_no_activity", n_done, 0);
      start_and = 1;
      track(0, 45, 0, 0);
      chk("after_reset_done_count", n_done, 1);
      chk("after_reset_done_cyc", done_cyc[0], 41);
      chk("after_reset_pass", and_pass, 1);

      // CNT_W=2 wrap with HOLD_CYCLES=2
      start_c2 = 1;
      cont_c2  = 1;
      track(1, 100, 4, 0);
      chk("c2_done_count", n_done, 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("c2_done%0d_cyc", i), done_cyc[i], 9 * (i + 1));
         chk($sformatf("c2_done%0d_cnt", i), done_cnt[i], (i + 1) % 4);
      end
      chk("c2_pass", c2_pass, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
